// File: rtl/branch_cond_unit_pkg.sv
// Shared definitions for the branch condition unit: condition codes, flag bit
// positions in the {N,Z,C,O} status word, and the redirect FSM states.
package branch_cond_unit_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_O = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Branch request (execute -> unit) and redirect (unit -> fetch) handshakes.
// master = the execute/fetch side, slave = the branch condition unit.
interface branch_cond_unit_if #(
    parameter int ADDR_W = 32
);
    logic              br_valid;
    logic [3:0]        br_cond;
    logic [ADDR_W-1:0] br_target;
    logic              br_ready;
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_target;
    logic              redir_ready;

    modport master (
        output br_valid, br_cond, br_target, redir_ready,
        input  br_ready, redir_valid, redir_target
    );

    modport slave (
        input  br_valid, br_cond, br_target, redir_ready,
        output br_ready, redir_valid, redir_target
    );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// Purely combinational evaluation of a 4-bit condition code against an
// {N,Z,C,O} flag word.
module cond_eval
    import branch_cond_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzco,
    output logic       taken
);

    logic n, z, c, o;

    assign n = nzco[FLG_N];
    assign z = nzco[FLG_Z];
    assign c = nzco[FLG_C];
    assign o = nzco[FLG_O];

    // GE/LT/GT/LE are signed comparisons: N==O means the result is non-negative
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_CS: taken = c;
            COND_CC: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = o;
            COND_VC: taken = !o;
            COND_HI: taken = c && !z;
            COND_LS: taken = !c || z;
            COND_GE: taken = (n == o);
            COND_LT: taken = (n != o);
            COND_GT: taken = !z && (n == o);
            COND_LE: taken = z || (n != o);
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: latches ALU flags, resolves branch conditions with
// same-cycle flag forwarding, and issues a registered redirect to fetch.
module branch_cond_unit
    import branch_cond_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flag_we,
    input  logic                  n_in,
    input  logic                  z_in,
    input  logic                  c_in,
    input  logic                  o_in,
    branch_cond_unit_if.slave     bus,
    output logic [3:0]            nzco_q,
    output logic [CNT_W-1:0]      taken_cnt,
    output logic [CNT_W-1:0]      ntaken_cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    state_e              state_q, state_d;
    logic                redir_valid_q, redir_valid_d;
    logic [ADDR_W-1:0]   redir_target_q, redir_target_d;
    logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0]    ntaken_cnt_q, ntaken_cnt_d;
    logic [3:0]          nzco_d;
    logic [3:0]          flags_in;
    logic [3:0]          eff_flags;
    logic                taken;
    logic                accept;

    assign flags_in  = {n_in, z_in, c_in, o_in};
    // Forward this cycle's ALU flags so a branch right after a compare sees them
    assign eff_flags = flag_we ? flags_in : nzco_q;

    cond_eval u_cond_eval (
        .cond  (bus.br_cond),
        .nzco  (eff_flags),
        .taken (taken)
    );

    assign bus.br_ready     = (state_q == ST_IDLE);
    assign accept           = bus.br_valid && bus.br_ready;
    assign bus.redir_valid  = redir_valid_q;
    assign bus.redir_target = redir_target_q;
    assign taken_cnt        = taken_cnt_q;
    assign ntaken_cnt       = ntaken_cnt_q;

    always_comb begin
        state_d        = state_q;
        redir_valid_d  = redir_valid_q;
        redir_target_d = redir_target_q;
        taken_cnt_d    = taken_cnt_q;
        ntaken_cnt_d   = ntaken_cnt_q;
        nzco_d         = flag_we ? flags_in : nzco_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && taken) begin
                    state_d        = ST_HOLD;
                    redir_valid_d  = 1'b1;
                    redir_target_d = bus.br_target;
                    taken_cnt_d    = sat_inc(taken_cnt_q);
                end else if (accept) begin
                    ntaken_cnt_d   = sat_inc(ntaken_cnt_q);
                end
            end
            ST_HOLD: begin
                // Redirect stays up until fetch takes it; new branches wait
                if (bus.redir_ready) begin
                    state_d       = ST_IDLE;
                    redir_valid_d = 1'b0;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                redir_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            redir_valid_q  <= 1'b0;
            redir_target_q <= '0;
            taken_cnt_q    <= '0;
            ntaken_cnt_q   <= '0;
            nzco_q         <= '0;
        end else begin
            state_q        <= state_d;
            redir_valid_q  <= redir_valid_d;
            redir_target_q <= redir_target_d;
            taken_cnt_q    <= taken_cnt_d;
            ntaken_cnt_q   <= ntaken_cnt_d;
            nzco_q         <= nzco_d;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Testbench for branch_cond_unit: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_branch_cond_unit;

    localparam int ADDR_W  = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flag_we = 1'b0;
    logic              n_in = 1'b0, z_in = 1'b0, c_in = 1'b0, o_in = 1'b0;
    logic [3:0]        nzco_q;
    logic [CNT_W-1:0]  taken_cnt;
    logic [CNT_W-1:0]  ntaken_cnt;

    branch_cond_unit_if #(.ADDR_W(ADDR_W)) bus ();

    branch_cond_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .n_in       (n_in),
        .z_in       (z_in),
        .c_in       (c_in),
        .o_in       (o_in),
        .bus        (bus),
        .nzco_q     (nzco_q),
        .taken_cnt  (taken_cnt),
        .ntaken_cnt (ntaken_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [3:0]        m_nzco;
    bit                m_busy;
    logic [ADDR_W-1:0] m_target;
    int                m_taken;
    int                m_ntaken;

    // Conditions come in complementary pairs; odd codes invert the even one
    function automatic bit ref_taken(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, o, base;
        n = f[3]; z = f[2]; c = f[1]; o = f[0];
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = o;
            3'd4:    base = c && !z;
            3'd5:    base = (n == o);
            3'd6:    base = !z && (n == o);
            default: base = 1'b1;
        endcase
        return base ^ cond[0];
    endfunction

    task automatic model_reset();
        m_nzco = 4'h0; m_busy = 1'b0; m_target = '0; m_taken = 0; m_ntaken = 0;
    endtask

    task automatic idle_inputs();
        flag_we = 1'b0; {n_in, z_in, c_in, o_in} = 4'h0;
        bus.br_valid = 1'b0; bus.br_cond = 4'h0; bus.br_target = '0;
        bus.redir_ready = 1'b0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        logic [3:0] fl, eff;
        fl  = {n_in, z_in, c_in, o_in};
        eff = flag_we ? fl : m_nzco;
        if (bus.br_valid && !m_busy) begin
            if (ref_taken(bus.br_cond, eff)) begin
                m_busy = 1'b1;
                m_target = bus.br_target;
                if (m_taken < CNT_MAX) m_taken++;
            end else if (m_ntaken < CNT_MAX) begin
                m_ntaken++;
            end
        end else if (m_busy && bus.redir_ready) begin
            m_busy = 1'b0;
        end
        if (flag_we) m_nzco = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [ADDR_W-1:0] tgt;
        idle_inputs();
        @(posedge clk);
        #1;
        tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL reset_redir_valid: got %b want 0", bus.redir_valid); end
        tests++; if (nzco_q !== 4'h0) begin fails++; $display("FAIL reset_nzco: got %h want 0", nzco_q); end
        tests++; if (taken_cnt !== '0 || ntaken_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %h/%h want 0/0", taken_cnt, ntaken_cnt); end
        rst_n = 1'b1;
        model_reset();
        tests++; if (bus.br_ready !== 1'b1) begin fails++; $display("FAIL reset_br_ready: got %b want 1", bus.br_ready); end
        // Enter HOLD with flags set, then pull reset asynchronously mid-cycle
        tgt = $urandom();
        flag_we = 1'b1; {n_in, z_in, c_in, o_in} = 4'hF;
        bus.br_valid = 1'b1; bus.br_cond = 4'hE; bus.br_target = tgt;
        tick();
        idle_inputs();
        tests++; if (bus.redir_valid !== 1'b1 || bus.redir_target !== tgt) begin fails++; $display("FAIL hold_before_reset: got %b/%h want 1/%h", bus.redir_valid, bus.redir_target, tgt); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL async_reset_redir: got %b want 0", bus.redir_valid); end
        tests++; if (nzco_q !== 4'h0 || taken_cnt !== '0) begin fails++; $display("FAIL async_reset_state: got nzco %h taken %h want 0/0", nzco_q, taken_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        tests++; if (bus.br_ready !== 1'b1 || bus.redir_valid !== 1'b0) begin fails++; $display("FAIL after_release: got ready %b valid %b want 1/0", bus.br_ready, bus.redir_valid); end
    endtask

    task automatic test_forwarding();
        do_reset();
        flag_we = 1'b1; {n_in, z_in, c_in, o_in} = 4'b0100;
        bus.br_valid = 1'b1; bus.br_cond = 4'h0; bus.br_target = 32'h100;
        tick();
        idle_inputs();
        tests++; if (bus.redir_valid !== 1'b1) begin fails++; $display("FAIL fwd_redir_valid: got %b want 1", bus.redir_valid); end
        tests++; if (bus.redir_target !== 32'h100) begin fails++; $display("FAIL fwd_target: got %h want 100", bus.redir_target); end
        tests++; if (nzco_q !== 4'b0100) begin fails++; $display("FAIL fwd_nzco: got %b want 0100", nzco_q); end
        tests++; if (taken_cnt !== 4'd1 || bus.br_ready !== 1'b0) begin fails++; $display("FAIL fwd_cnt_ready: got %h/%b want 1/0", taken_cnt, bus.br_ready); end
        bus.redir_ready = 1'b1;
        tick();
        bus.redir_ready = 1'b0;
        tests++; if (bus.redir_valid !== 1'b0 || bus.br_ready !== 1'b1) begin fails++; $display("FAIL fwd_release: got %b/%b want 0/1", bus.redir_valid, bus.br_ready); end
    endtask

    task automatic test_signed();
        logic [ADDR_W-1:0] tgt;
        do_reset();
        flag_we = 1'b1; {n_in, z_in, c_in, o_in} = 4'b1000;
        tick();
        idle_inputs();
        tests++; if (nzco_q !== 4'b1000) begin fails++; $display("FAIL signed_latch: got %b want 1000", nzco_q); end
        tgt = $urandom();
        bus.br_valid = 1'b1; bus.br_cond = 4'hB; bus.br_target = tgt;
        tick();
        idle_inputs();
        tests++; if (bus.redir_valid !== 1'b1 || bus.redir_target !== tgt) begin fails++; $display("FAIL signed_lt: got %b/%h want 1/%h", bus.redir_valid, bus.redir_target, tgt); end
        bus.redir_ready = 1'b1;
        tick();
        idle_inputs();
        bus.br_valid = 1'b1; bus.br_cond = 4'hA; bus.br_target = ~tgt;
        tick();
        idle_inputs();
        tests++; if (bus.redir_valid !== 1'b0) begin fails++; $display("FAIL signed_ge_redir: got %b want 0", bus.redir_valid); end
        tests++; if (ntaken_cnt !== 4'd1 || taken_cnt !== 4'd1) begin fails++; $display("FAIL signed_counts: got %h/%h want 1/1", taken_cnt, ntaken_cnt); end
    endtask

    task automatic test_backpressure();
        logic [ADDR_W-1:0] tgt;
        logic [3:0] f;
        do_reset();
        tgt = $urandom();
        bus.br_valid = 1'b1; bus.br_cond = 4'hE; bus.br_target = tgt;
        tick();
        for (int i = 0; i < 5; i++) begin
            f = 4'($urandom_range(0, 15));
            flag_we = 1'b1; {n_in, z_in, c_in, o_in} = f;
            bus.br_valid = 1'b1; bus.br_cond = 4'hE; bus.br_target = tgt ^ 32'hFFFF;
            tick();
            tests++;
            if (bus.redir_valid !== 1'b1 || bus.redir_target !== tgt || bus.br_ready !== 1'b0 || nzco_q !== f) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v%b t%h r%b f%h want v1 t%h r0 f%h", i, bus.redir_valid, bus.redir_target, bus.br_ready, nzco_q, tgt, f);
            end
        end
        idle_inputs();
        bus.redir_ready = 1'b1;
        tick();
        idle_inputs();
        tests++; if (bus.redir_valid !== 1'b0 || bus.br_ready !== 1'b1 || taken_cnt !== 4'd1) begin fails++; $display("FAIL bp_release: got v%b r%b cnt%h want v0 r1 cnt1", bus.redir_valid, bus.br_ready, taken_cnt); end
    endtask

    task automatic test_sweep();
        logic [ADDR_W-1:0] tgt;
        bit exp, fwd;
        int guard;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                fwd = 1'($urandom_range(0, 1));
                tgt = $urandom();
                if (!fwd) begin
                    flag_we = 1'b1; {n_in, z_in, c_in, o_in} = 4'(f);
                    tick();
                    idle_inputs();
                end else begin
                    flag_we = 1'b1; {n_in, z_in, c_in, o_in} = 4'(f);
                end
                bus.br_valid = 1'b1; bus.br_cond = 4'(c); bus.br_target = tgt;
                tick();
                idle_inputs();
                exp = ref_taken(4'(c), 4'(f));
                tests++;
                if (bus.redir_valid !== exp || (exp && bus.redir_target !== tgt)) begin
                    fails++;
                    $display("FAIL sweep c%h f%h fwd%0d: got v%b t%h want v%b t%h", c, f, fwd, bus.redir_valid, bus.redir_target, exp, tgt);
                end
                guard = 0;
                while (m_busy && guard < 10) begin
                    bus.redir_ready = 1'($urandom_range(0, 1));
                    tick();
                    guard++;
                end
                bus.redir_ready = 1'b0;
                if (m_busy) begin
                    tests++; fails++;
                    $display("FAIL sweep_drain: redirect still pending after %0d cycles", guard);
                end
            end
        end
        tests++;
        if (taken_cnt !== CNT_W'(m_taken) || ntaken_cnt !== CNT_W'(m_ntaken)) begin
            fails++;
            $display("FAIL sweep_counts: got %h/%h want %h/%h", taken_cnt, ntaken_cnt, m_taken, m_ntaken);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.br_valid = 1'b1; bus.br_cond = 4'hE; bus.br_target = $urandom();
            tick();
            idle_inputs();
            bus.redir_ready = 1'b1;
            tick();
            idle_inputs();
            if (i == 14) begin
                tests++; if (taken_cnt !== 4'hF) begin fails++; $display("FAIL sat_reach: got %h want f", taken_cnt); end
            end
        end
        tests++; if (taken_cnt !== 4'hF) begin fails++; $display("FAIL sat_taken: got %h want f", taken_cnt); end
        for (int i = 0; i < 20; i++) begin
            bus.br_valid = 1'b1; bus.br_cond = 4'hF; bus.br_target = $urandom();
            tick();
        end
        idle_inputs();
        tests++; if (ntaken_cnt !== 4'hF || taken_cnt !== 4'hF) begin fails++; $display("FAIL sat_ntaken: got %h/%h want f/f", taken_cnt, ntaken_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            flag_we = 1'($urandom_range(0, 1));
            {n_in, z_in, c_in, o_in} = 4'($urandom_range(0, 15));
            bus.br_valid = ($urandom_range(0, 3) != 0);
            bus.br_cond = 4'($urandom_range(0, 15));
            bus.br_target = $urandom();
            bus.redir_ready = 1'($urandom_range(0, 1));
            // Early clear keeps the saturating counters in range for longer
            if (i == 200) begin
                do_reset();
            end
            tick();
            tests++;
            if (bus.redir_valid !== m_busy || bus.redir_target !== m_target || bus.br_ready !== !m_busy ||
                nzco_q !== m_nzco || taken_cnt !== CNT_W'(m_taken) || ntaken_cnt !== CNT_W'(m_ntaken)) begin
                fails++;
                $display("FAIL b2b[%0d]: got v%b t%h r%b f%h tc%h nc%h want v%b t%h r%b f%h tc%h nc%h",
                         i, bus.redir_valid, bus.redir_target, bus.br_ready, nzco_q, taken_cnt, ntaken_cnt,
                         m_busy, m_target, !m_busy, m_nzco, m_taken, m_ntaken);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_forwarding();
        test_signed();
        test_backpressure();
        test_sweep();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
